// File: rtl/hdlc_line_checker_pkg.sv
// Shared constants for the HDLC line checker: FSM state codes, sticky error
// bit positions and the flag octet from which the run-length limits derive.
package hdlc_chk_pkg;

    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] SYNC  = 2'd1;
    localparam logic [1:0] FRAME = 2'd2;

    localparam int ERR_ALIGN = 0;
    localparam int ERR_OVF   = 1;
    localparam int ERR_FLAG  = 2;
    localparam int ERR_ABORT = 3;
    localparam int ERR_W     = 4;

    localparam logic [7:0] FLAG_PATTERN = 8'h7E;
    // Ones inside a flag; one fewer is the stuffing threshold, one more an abort.
    localparam int FLAG_ONES = $countones(FLAG_PATTERN);
    // Counted bits of a closing flag (its 0111111 prefix) that precede the final zero.
    localparam int FLAG_PREFIX_BITS = FLAG_ONES + 1;

endpackage

// File: rtl/hdlc_line_checker_if.sv
// Observed receive-side bundle: serial data, bit-valid and the DUT flag strobe.
interface hdlc_line_checker_if #(
    parameter int N_CH = 1
);
    logic [N_CH-1:0] Rx;
    logic [N_CH-1:0] RxEN;
    logic [N_CH-1:0] Dut_FlagDetect;

    modport master (output Rx, output RxEN, output Dut_FlagDetect);
    modport slave  (input  Rx, input  RxEN, input  Dut_FlagDetect);
endinterface

// File: rtl/hdlc_line_checker_chan.sv
// One HDLC channel: flag/abort/idle hunting, zero destuffing, frame sizing,
// sticky errors and the fixed-latency cross-check of the DUT flag strobe.
module hdlc_chk_chan
    import hdlc_chk_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 128,
    parameter int IDLE_BITS       = 8,
    parameter int FLAG_LAT        = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             rx_i,
    input  logic             en_i,
    input  logic             dut_flag_i,
    input  logic             clr_err_i,
    output logic             flag_o,
    output logic             abort_o,
    output logic             idle_o,
    output logic             frame_end_o,
    output logic [7:0]       frame_size_o,
    output logic [ERR_W-1:0] err_o,
    output logic [ERR_W-1:0] err_evt_o
);

    // Bit counter must reach at least 256 bytes plus a flag so the reported
    // size can saturate at 255 instead of wrapping.
    localparam int MAXB     = (MAX_FRAME_BYTES > 255) ? MAX_FRAME_BYTES : 255;
    localparam int BC_W     = $clog2((MAXB + 2) * 8);
    localparam int BL_W     = $clog2(FLAG_LAT + 1);
    localparam logic [BC_W-1:0] BC_MAX    = '1;
    localparam logic [BC_W-1:0] PREFIX    = BC_W'(FLAG_PREFIX_BITS);
    // Payload is provably past the limit once this many bits are counted,
    // since at most a flag prefix of them can still belong to a closing flag.
    localparam logic [BC_W-1:0] OVF_BITS  = BC_W'((MAX_FRAME_BYTES + 1) * 8 + FLAG_PREFIX_BITS);
    localparam logic [2:0]      RUN_FLAG  = 3'(FLAG_ONES);
    localparam logic [2:0]      RUN_STUFF = 3'(FLAG_ONES - 1);
    localparam logic [3:0]      IDLE_HIT  = 4'(IDLE_BITS - 1);

    logic [1:0]          state_q, state_d;
    logic [2:0]          ones_q, ones_d;
    logic [3:0]          idle_cnt_q, idle_cnt_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic                ovf_q, ovf_d;
    logic                flag_q, abort_q, idle_p_q, fend_q, fend_d;
    logic [7:0]          size_q, size_d;
    logic [ERR_W-1:0]    err_q, err_d, evt;
    logic [FLAG_LAT-1:0] fl_pipe_q;
    logic [BL_W-1:0]     blank_q;

    logic                is_flag, is_stuff, is_abort, is_idle;
    logic [BC_W-1:0]     payload;
    logic [BC_W-4:0]     pbytes;

    always_comb begin
        is_flag  = en_i && !rx_i && (ones_q == RUN_FLAG);
        is_stuff = en_i && !rx_i && (ones_q == RUN_STUFF);
        is_abort = en_i &&  rx_i && (ones_q == RUN_FLAG);
        is_idle  = en_i &&  rx_i && (idle_cnt_q == IDLE_HIT);

        // Shared-zero flags can close with fewer counted bits than a prefix.
        payload  = (bitcnt_q > PREFIX) ? (bitcnt_q - PREFIX) : '0;
        pbytes   = payload[BC_W-1:3];

        ones_d     = ones_q;
        idle_cnt_d = idle_cnt_q;
        if (en_i) begin
            ones_d     = !rx_i ? 3'd0 : ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1);
            idle_cnt_d = !rx_i ? 4'd0 : ((idle_cnt_q == 4'hF) ? 4'hF : idle_cnt_q + 4'd1);
        end

        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        ovf_d    = ovf_q;
        fend_d   = 1'b0;
        size_d   = size_q;
        evt      = '0;
        if (en_i) begin
            case (state_q)
                HUNT: if (is_flag) state_d = SYNC;
                SYNC: begin
                    if (is_abort) begin
                        state_d = HUNT;
                    end else if (!is_flag && !is_stuff) begin
                        state_d  = FRAME;
                        bitcnt_d = BC_W'(1);
                        ovf_d    = 1'b0;
                    end
                end
                FRAME: begin
                    if (is_abort) begin
                        state_d        = HUNT;
                        evt[ERR_ABORT] = 1'b1;
                    end else if (is_flag) begin
                        state_d = SYNC;
                        if (payload != '0) begin
                            fend_d         = 1'b1;
                            size_d         = (pbytes > (BC_W-3)'(255)) ? 8'hFF : pbytes[7:0];
                            evt[ERR_ALIGN] = |payload[2:0];
                        end
                    end else if (!is_stuff) begin
                        bitcnt_d = (bitcnt_q == BC_MAX) ? bitcnt_q : bitcnt_q + BC_W'(1);
                        if (!ovf_q && bitcnt_d >= OVF_BITS) begin
                            ovf_d        = 1'b1;
                            evt[ERR_OVF] = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
            if (is_idle) state_d = HUNT;
        end

        evt[ERR_FLAG] = (blank_q == '0) && (dut_flag_i != fl_pipe_q[FLAG_LAT-1]);
        // A fresh event outranks a simultaneous clear.
        err_d = (clr_err_i ? '0 : err_q) | evt;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= HUNT;
            ones_q     <= '0;
            idle_cnt_q <= '0;
            bitcnt_q   <= '0;
            ovf_q      <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            idle_p_q   <= 1'b0;
            fend_q     <= 1'b0;
            size_q     <= '0;
            err_q      <= '0;
            fl_pipe_q  <= '0;
            blank_q    <= BL_W'(FLAG_LAT);
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            idle_cnt_q <= idle_cnt_d;
            bitcnt_q   <= bitcnt_d;
            ovf_q      <= ovf_d;
            flag_q     <= is_flag;
            abort_q    <= is_abort;
            idle_p_q   <= is_idle;
            fend_q     <= fend_d;
            size_q     <= size_d;
            err_q      <= err_d;
            fl_pipe_q  <= FLAG_LAT'({fl_pipe_q, is_flag});
            blank_q    <= (blank_q != '0) ? blank_q - BL_W'(1) : '0;
        end
    end

    assign flag_o       = flag_q;
    assign abort_o      = abort_q;
    assign idle_o       = idle_p_q;
    assign frame_end_o  = fend_q;
    assign frame_size_o = size_q;
    assign err_o        = err_q;
    assign err_evt_o    = evt;

endmodule

// File: rtl/hdlc_line_checker.sv
// Multi-channel HDLC line checker: per-channel checkers plus a global
// saturating count of error events.
module hdlc_line_checker
    import hdlc_chk_pkg::*;
#(
    parameter int N_CH            = 1,
    parameter int MAX_FRAME_BYTES = 128,
    parameter int IDLE_BITS       = 8,
    parameter int FLAG_LAT        = 2,
    parameter int CNT_W           = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    hdlc_line_checker_if.slave      line,
    input  logic                    ClrErr,
    output logic [N_CH-1:0]         Flag_o,
    output logic [N_CH-1:0]         Abort_o,
    output logic [N_CH-1:0]         Idle_o,
    output logic [N_CH-1:0]         FrameEnd_o,
    output logic [8*N_CH-1:0]       FrameSize_o,
    output logic [ERR_W*N_CH-1:0]   Err_o,
    output logic [CNT_W-1:0]        ErrCnt_o
);

    localparam int POP_W = $clog2(ERR_W * N_CH + 1);

    logic [ERR_W*N_CH-1:0] evt_all;
    logic [POP_W-1:0]      pop;
    logic [CNT_W:0]        cnt_sum;
    logic [CNT_W-1:0]      errcnt_q, errcnt_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        hdlc_chk_chan #(
            .MAX_FRAME_BYTES (MAX_FRAME_BYTES),
            .IDLE_BITS       (IDLE_BITS),
            .FLAG_LAT        (FLAG_LAT)
        ) u_chan (
            .Clk          (Clk),
            .Rst          (Rst),
            .rx_i         (line.Rx[i]),
            .en_i         (line.RxEN[i]),
            .dut_flag_i   (line.Dut_FlagDetect[i]),
            .clr_err_i    (ClrErr),
            .flag_o       (Flag_o[i]),
            .abort_o      (Abort_o[i]),
            .idle_o       (Idle_o[i]),
            .frame_end_o  (FrameEnd_o[i]),
            .frame_size_o (FrameSize_o[8*i +: 8]),
            .err_o        (Err_o[ERR_W*i +: ERR_W]),
            .err_evt_o    (evt_all[ERR_W*i +: ERR_W])
        );
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < ERR_W * N_CH; k++) pop = pop + POP_W'(evt_all[k]);
        cnt_sum  = {1'b0, errcnt_q} + (CNT_W+1)'(pop);
        errcnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) errcnt_q <= '0;
        else     errcnt_q <= errcnt_d;
    end

    assign ErrCnt_o = errcnt_q;

endmodule

// File: tb/tb_hdlc_line_checker.sv
// Directed bench for hdlc_line_checker with two channels: frames are bit-stuffed
// by the bench and the DUT flag strobe is emulated at a per-channel latency.
module tb_hdlc_line_checker;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ClrErr;
    logic [1:0]  Flag_o, Abort_o, Idle_o, FrameEnd_o;
    logic [15:0] FrameSize_o;
    logic [7:0]  Err_o;
    logic [15:0] ErrCnt_o;

    int errors = 0;
    int checks = 0;
    int tb_ones;
    int lat [2];
    logic [7:0] mhist [2];
    logic clr;
    int nflag [2], nabort [2], nidle [2], nfend [2];

    hdlc_line_checker_if #(.N_CH(2)) bus ();

    hdlc_line_checker #(
        .N_CH(2), .MAX_FRAME_BYTES(128), .IDLE_BITS(8), .FLAG_LAT(2), .CNT_W(16)
    ) dut (
        .Clk(Clk), .Rst(Rst), .line(bus), .ClrErr(ClrErr),
        .Flag_o(Flag_o), .Abort_o(Abort_o), .Idle_o(Idle_o), .FrameEnd_o(FrameEnd_o),
        .FrameSize_o(FrameSize_o), .Err_o(Err_o), .ErrCnt_o(ErrCnt_o)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic [1:0] rx, input logic [1:0] en, input logic [1:0] mk);
        logic [1:0] fdet;
        @(negedge Clk);
        for (int c = 0; c < 2; c++) begin
            mhist[c] = {mhist[c][6:0], mk[c]};
            fdet[c]  = mhist[c][lat[c]];
        end
        bus.Rx = rx;
        bus.RxEN = en;
        bus.Dut_FlagDetect = fdet;
        ClrErr = clr;
        @(posedge Clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (Flag_o[c])     nflag[c]++;
            if (Abort_o[c])    nabort[c]++;
            if (Idle_o[c])     nidle[c]++;
            if (FrameEnd_o[c]) nfend[c]++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'b00, 2'b00, 2'b00);
    endtask

    task automatic send_raw(input logic b, input logic [1:0] m, input logic mark);
        step({2{b}} & m, m, mark ? m : 2'b00);
    endtask

    task automatic send_flag(input logic [1:0] m);
        send_raw(1'b0, m, 1'b0);
        repeat (6) send_raw(1'b1, m, 1'b0);
        send_raw(1'b0, m, 1'b1);
        tb_ones = 0;
    endtask

    task automatic send_dbit(input logic b, input logic [1:0] m);
        send_raw(b, m, 1'b0);
        if (b) begin
            tb_ones++;
            if (tb_ones == 5) begin
                send_raw(1'b0, m, 1'b0);
                tb_ones = 0;
            end
        end else begin
            tb_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [1:0] m);
        for (int i = 0; i < 8; i++) send_dbit(d[i], m);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst = 1'b1;
        ClrErr = 1'b0;
        clr = 1'b0;
        bus.Rx = 2'b00;
        bus.RxEN = 2'b00;
        bus.Dut_FlagDetect = 2'b00;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        tb_ones = 0;
        for (int c = 0; c < 2; c++) begin
            lat[c] = 2; mhist[c] = '0;
            nflag[c] = 0; nabort[c] = 0; nidle[c] = 0; nfend[c] = 0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        if ({Flag_o, Abort_o, Idle_o, FrameEnd_o} !== 8'h00) begin
            errors++; $display("FAIL reset_pulses: got %b want 0", {Flag_o, Abort_o, Idle_o, FrameEnd_o});
        end
        checks++;
        if (FrameSize_o !== 16'h0) begin errors++; $display("FAIL reset_size: got %h want 0", FrameSize_o); end
        checks++;
        if (Err_o !== 8'h0) begin errors++; $display("FAIL reset_err: got %b want 0", Err_o); end
        checks++;
        if (ErrCnt_o !== 16'h0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", ErrCnt_o); end
        checks++;
    endtask

    task automatic test_basic_frame();
        apply_reset();
        idle(4);
        send_flag(2'b01);
        send_byte(8'hA5, 2'b01); send_byte(8'h0F, 2'b01); send_byte(8'h3C, 2'b01);
        send_flag(2'b01);
        idle(5);
        if (nfend[0] !== 1) begin errors++; $display("FAIL basic_fend: got %0d want 1", nfend[0]); end
        checks++;
        if (FrameSize_o[7:0] !== 8'd3) begin errors++; $display("FAIL basic_size: got %0d want 3", FrameSize_o[7:0]); end
        checks++;
        if (nflag[0] !== 2) begin errors++; $display("FAIL basic_flags: got %0d want 2", nflag[0]); end
        checks++;
        if (Err_o !== 8'h0) begin errors++; $display("FAIL basic_err: got %b want 0", Err_o); end
        checks++;
        if (ErrCnt_o !== 16'd0) begin errors++; $display("FAIL basic_errcnt: got %0d want 0", ErrCnt_o); end
        checks++;
    endtask

    task automatic test_stuffing();
        apply_reset();
        idle(4);
        send_flag(2'b01);
        send_byte(8'hFF, 2'b01); send_byte(8'h12, 2'b01);
        send_flag(2'b01);
        idle(5);
        if (FrameSize_o[7:0] !== 8'd2) begin errors++; $display("FAIL stuff_size: got %0d want 2", FrameSize_o[7:0]); end
        checks++;
        if (nabort[0] !== 0) begin errors++; $display("FAIL stuff_abort: got %0d want 0", nabort[0]); end
        checks++;
        if (nfend[0] !== 1) begin errors++; $display("FAIL stuff_fend: got %0d want 1", nfend[0]); end
        checks++;
        if (Err_o !== 8'h0) begin errors++; $display("FAIL stuff_err: got %b want 0", Err_o); end
        checks++;
    endtask

    task automatic test_misaligned();
        apply_reset();
        idle(4);
        send_flag(2'b01);
        send_byte(8'h96, 2'b01); send_byte(8'h3B, 2'b01);
        send_dbit(1'b1, 2'b01); send_dbit(1'b0, 2'b01); send_dbit(1'b1, 2'b01);
        send_flag(2'b01);
        idle(5);
        if (nfend[0] !== 1) begin errors++; $display("FAIL align_fend: got %0d want 1", nfend[0]); end
        checks++;
        if (FrameSize_o[7:0] !== 8'd2) begin errors++; $display("FAIL align_size: got %0d want 2", FrameSize_o[7:0]); end
        checks++;
        if (Err_o !== 8'b0000_0001) begin errors++; $display("FAIL align_err: got %b want 00000001", Err_o); end
        checks++;
        if (ErrCnt_o !== 16'd1) begin errors++; $display("FAIL align_errcnt: got %0d want 1", ErrCnt_o); end
        checks++;
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(1);
        if (Err_o !== 8'h0) begin errors++; $display("FAIL clr_err: got %b want 0", Err_o); end
        checks++;
        if (ErrCnt_o !== 16'd1) begin errors++; $display("FAIL clr_errcnt: got %0d want 1", ErrCnt_o); end
        checks++;
    endtask

    task automatic test_abort_idle();
        apply_reset();
        idle(4);
        send_flag(2'b01);
        for (int i = 1; i <= 5; i++) send_byte(8'(i * 17), 2'b01);
        send_raw(1'b0, 2'b01, 1'b0);
        repeat (6) send_raw(1'b1, 2'b01, 1'b0);
        if (Abort_o[0] !== 1'b0) begin errors++; $display("FAIL abort_early: got %b want 0", Abort_o[0]); end
        checks++;
        send_raw(1'b1, 2'b01, 1'b0);
        if (Abort_o[0] !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", Abort_o[0]); end
        checks++;
        if (Err_o !== 8'b0000_1000) begin errors++; $display("FAIL abort_err: got %b want 00001000", Err_o); end
        checks++;
        send_raw(1'b1, 2'b01, 1'b0);
        if ({Abort_o[0], Idle_o[0]} !== 2'b01) begin
            errors++; $display("FAIL idle_pulse: abort/idle got %b want 01", {Abort_o[0], Idle_o[0]});
        end
        checks++;
        repeat (6) send_raw(1'b1, 2'b01, 1'b0);
        if (nabort[0] !== 1 || nidle[0] !== 1) begin
            errors++; $display("FAIL abort_idle_once: abort=%0d idle=%0d want 1/1", nabort[0], nidle[0]);
        end
        checks++;
        send_flag(2'b01);
        send_byte(8'h5A, 2'b01);
        send_flag(2'b01);
        idle(5);
        if (nfend[0] !== 1 || FrameSize_o[7:0] !== 8'd1) begin
            errors++; $display("FAIL abort_resync: fend=%0d size=%0d want 1/1", nfend[0], FrameSize_o[7:0]);
        end
        checks++;
        if (ErrCnt_o !== 16'd1) begin errors++; $display("FAIL abort_errcnt: got %0d want 1", ErrCnt_o); end
        checks++;
    endtask

    task automatic test_overflow();
        apply_reset();
        idle(4);
        send_flag(2'b01);
        for (int i = 0; i < 130; i++) send_byte(8'(i), 2'b01);
        send_flag(2'b01);
        idle(5);
        if (Err_o !== 8'b0000_0010) begin errors++; $display("FAIL ovf_err: got %b want 00000010", Err_o); end
        checks++;
        if (ErrCnt_o !== 16'd1) begin errors++; $display("FAIL ovf_once: got %0d want 1", ErrCnt_o); end
        checks++;
        if (FrameSize_o[7:0] !== 8'd130) begin errors++; $display("FAIL ovf_size: got %0d want 130", FrameSize_o[7:0]); end
        checks++;
        if (nfend[0] !== 1) begin errors++; $display("FAIL ovf_fend: got %0d want 1", nfend[0]); end
        checks++;
    endtask

    task automatic test_flag_xcheck();
        apply_reset();
        idle(4);
        lat[1] = 3;
        send_flag(2'b11);
        idle(6);
        if (Err_o[3:0] !== 4'b0000) begin errors++; $display("FAIL xchk_ch0: got %b want 0000", Err_o[3:0]); end
        checks++;
        if (Err_o[7:4] !== 4'b0100) begin errors++; $display("FAIL xchk_ch1: got %b want 0100", Err_o[7:4]); end
        checks++;
        if (ErrCnt_o !== 16'd2) begin errors++; $display("FAIL xchk_errcnt: got %0d want 2", ErrCnt_o); end
        checks++;
    endtask

    task automatic test_rst_midframe();
        apply_reset();
        idle(4);
        send_flag(2'b01);
        send_byte(8'hC3, 2'b01); send_byte(8'h18, 2'b01);
        apply_reset();
        idle(4);
        if (nfend[0] !== 0 || FrameSize_o[7:0] !== 8'd0) begin
            errors++; $display("FAIL rst_discard: fend=%0d size=%0d want 0/0", nfend[0], FrameSize_o[7:0]);
        end
        checks++;
        send_flag(2'b01);
        send_byte(8'h81, 2'b01);
        send_flag(2'b01);
        idle(5);
        if (nfend[0] !== 1 || FrameSize_o[7:0] !== 8'd1) begin
            errors++; $display("FAIL rst_resync: fend=%0d size=%0d want 1/1", nfend[0], FrameSize_o[7:0]);
        end
        checks++;
        if (ErrCnt_o !== 16'd0) begin errors++; $display("FAIL rst_errcnt: got %0d want 0", ErrCnt_o); end
        checks++;
    endtask

    initial begin
        Rst = 1'b1;
        ClrErr = 1'b0;
        clr = 1'b0;
        bus.Rx = 2'b00;
        bus.RxEN = 2'b00;
        bus.Dut_FlagDetect = 2'b00;
        test_reset();
        test_basic_frame();
        test_stuffing();
        test_misaligned();
        test_abort_idle();
        test_overflow();
        test_flag_xcheck();
        test_rst_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
